multi_timer: RTL and testbench

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer_if.sv | 36 +++
 rtl/multi_timer.sv | 147 ++++++++++++++
 tb/tb_multi_timer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_timer_if.sv
// multi_timer_if: register bus between a host and the multi_timer block.
//
// Signals
//   addr    : byte address; addr[6:4] = channel, addr[3:2] = register
//   we      : write strobe, sampled on the rising clock edge
//   din     : write data
//   dout    : read data for addr, combinational
//   irq     : per-channel interrupt request (level)
//   irq_any : OR of irq
//   state   : per-channel FSM state, 2 bits per channel, channel i at [2*i +: 2]
//             (0 = IDLE, 1 = LOAD, 2 = CNT, 3 = INT)
//
// Bus protocol: there is no valid/ready pair. A write takes effect on the
// rising edge where we=1, using that cycle's addr and din. A read is the
// combinational value of dout for the current addr and needs no strobe.
interface multi_timer_if #(
    parameter int NCH = 2
) ();
    logic [31:0]      addr;
    logic             we;
    logic [31:0]      din;
    logic [31:0]      dout;
    logic [NCH-1:0]   irq;
    logic             irq_any;
    logic [2*NCH-1:0] state;

    modport master (
        output addr, we, din,
        input  dout, irq, irq_any, state
    );

    modport slave (
        input  addr, we, din,
        output dout, irq, irq_any, state
    );
endinterface

// File: rtl/multi_timer.sv
// multi_timer: NCH independent down-counting timer channels behind a small
// register bus.
//
// Ports
//   clk   : single clock, all state updates on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : multi_timer_if slave (addr/we/din in; dout/irq/irq_any/state out)
//
// Per-channel registers (channel base = ch*0x10)
//   0x0 CTRL   : bit0 EN, bits2:1 MODE (1 = auto-reload, else one-shot),
//                bit3 IM (irq enable), bit4 PEND (write 1 to clear)
//   0x4 PRESET : WIDTH bits, read/write
//   0x8 COUNT  : WIDTH bits, read-only
//   0xC        : reserved, reads 0
module multi_timer #(
    parameter int NCH   = 2,
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    multi_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    logic [NCH-1:0][31:0] rd_ctrl;
    logic [NCH-1:0][31:0] rd_preset;
    logic [NCH-1:0][31:0] rd_count;
    logic [NCH-1:0]       irq_vec;
    logic [2*NCH-1:0]     state_vec;

    logic [2:0]  sel_ch;
    logic [1:0]  sel_reg;
    logic [31:0] rdata;

    assign sel_ch  = bus.addr[6:4];
    assign sel_reg = bus.addr[3:2];

    // Address bits outside [6:2] and the upper data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.addr, bus.din};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state;
        logic             en;
        logic             im;
        logic             pend;
        logic [1:0]       mode;
        logic [WIDTH-1:0] preset;
        logic [WIDTH-1:0] count;
        logic             wr_ch;
        logic             wr_ctrl;
        logic             wr_preset;

        assign wr_ch     = bus.we && (sel_ch == 3'(i));
        assign wr_ctrl   = wr_ch && (sel_reg == 2'd0);
        assign wr_preset = wr_ch && (sel_reg == 2'd1);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state  <= IDLE;
                en     <= 1'b0;
                im     <= 1'b0;
                pend   <= 1'b0;
                mode   <= 2'd0;
                preset <= '0;
                count  <= '0;
            end else begin
                if (wr_preset)
                    preset <= bus.din[WIDTH-1:0];

                if (wr_ctrl) begin
                    en   <= bus.din[0];
                    mode <= bus.din[2:1];
                    im   <= bus.din[3];
                    if (bus.din[4])
                        pend <= 1'b0;
                end

                // The FSM assignments come after the software writes so that a
                // hardware PEND set overrides a same-edge W1C.
                case (state)
                    IDLE: begin
                        if (en)
                            state <= LOAD;
                    end
                    LOAD: begin
                        count <= preset;
                        state <= CNT;
                    end
                    CNT: begin
                        if (!en) begin
                            state <= IDLE;
                        end else if (count > WIDTH'(1)) begin
                            count <= count - WIDTH'(1);
                        end else begin
                            count <= '0;
                            pend  <= 1'b1;
                            state <= INT;
                        end
                    end
                    INT: begin
                        if (mode == 2'd1) begin
                            state <= LOAD;
                        end else begin
                            // A software CTRL write on this edge keeps its EN.
                            if (!wr_ctrl)
                                en <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign rd_ctrl[i]           = {27'd0, pend, im, mode, en};
        assign rd_preset[i]         = 32'(preset);
        assign rd_count[i]          = 32'(count);
        assign irq_vec[i]           = pend & im;
        assign state_vec[2*i +: 2]  = state;
    end

    // Channels at or above NCH never match, so they read 0.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_ch == 3'(k)) begin
                case (sel_reg)
                    2'd0:    rdata = rd_ctrl[k];
                    2'd1:    rdata = rd_preset[k];
                    2'd2:    rdata = rd_count[k];
                    default: rdata = '0;
                endcase
            end
        end
    end

    assign bus.dout    = rdata;
    assign bus.irq     = irq_vec;
    assign bus.irq_any = |irq_vec;
    assign bus.state   = state_vec;
endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;
    localparam int NCH   = 2;
    localparam int WIDTH = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   ncmp  = 0;
    int   nfail = 0;

    multi_timer_if #(.NCH(NCH)) bus ();

    multi_timer #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] a(input int ch, input int r);
        return 32'(ch * 16 + r * 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.addr = addr;
        bus.din  = data;
        bus.we   = 1'b1;
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.addr = addr;
        #1;
        check(tag, bus.dout, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("rst_irq", 32'(bus.irq), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Closed-form view of one channel enabled at edge d=0 from a freshly
    // reset state: the first fire is L = max(P,1)+2 edges later, auto-reload
    // repeats every L edges, and COUNT walks P, P-1, ... starting 2 edges
    // after the enable.
    function automatic void model(input int p, input int mode, input int d,
                                  output int cnt, output int pend, output int en);
        int L;
        int e;
        L = ((p < 1) ? 1 : p) + 2;
        if (d < 2) begin
            cnt = 0;
        end else if (mode != 1 && d >= L) begin
            cnt = 0;
        end else begin
            e   = (d - 2) % L;
            cnt = (e < L - 2) ? p - e : 0;
        end
        pend = (d >= L) ? 1 : 0;
        en   = (mode == 1) ? 1 : ((d <= L) ? 1 : 0);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bus.addr = '0;
        bus.din  = '0;
        bus.we   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_rd("rst_ctrl0",  a(0, 0), 32'd0);
        chk_rd("rst_pre0",   a(0, 1), 32'd0);
        chk_rd("rst_cnt0",   a(0, 2), 32'd0);
        chk_rd("rst_ctrl1",  a(1, 0), 32'd0);
        check("rst_irq_vec", 32'(bus.irq), 32'd0);
        check("rst_irq_any", 32'(bus.irq_any), 32'd0);
        check("rst_state",   32'(bus.state), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // One-shot on ch0, PRESET=3
        wr(a(0, 1), 32'd3);
        wr(a(0, 0), 32'h9);
        step(); check("os_state_load", 32'(bus.state[1:0]), 32'(S_LOAD));
        step(); chk_rd("os_cnt_t2", a(0, 2), 32'd3);
        step(); chk_rd("os_cnt_t3", a(0, 2), 32'd2);
        step(); chk_rd("os_cnt_t4", a(0, 2), 32'd1);
        step(); chk_rd("os_cnt_t5", a(0, 2), 32'd0);
        chk_rd("os_ctrl_t5", a(0, 0), 32'h19);
        check("os_irq_t5", 32'(bus.irq), 32'd1);
        check("os_irqany_t5", 32'(bus.irq_any), 32'd1);
        step(); chk_rd("os_ctrl_t6", a(0, 0), 32'h18);
        check("os_state_t6", 32'(bus.state[1:0]), 32'(S_IDLE));
        step(); step(); check("os_irq_hold", 32'(bus.irq), 32'd1);
        wr(a(0, 0), 32'h18);
        check("os_irq_cleared", 32'(bus.irq), 32'd0);

        // Auto-reload on ch1, PRESET=2: PEND every 4 edges
        wr(a(1, 1), 32'd2);
        wr(a(1, 0), 32'hB);
        step(); step(); step();
        check("ar_irq_t3", 32'(bus.irq), 32'd0);
        step();
        check("ar_irq_t4", 32'(bus.irq), 32'd2);
        chk_rd("ar_ctrl_t4", a(1, 0), 32'h1B);
        for (int r = 0; r < 2; r++) begin
            wr(a(1, 0), 32'h1B);
            check("ar_irq_w1c", 32'(bus.irq), 32'd0);
            step(); step();
            check("ar_irq_before", 32'(bus.irq), 32'd0);
            step();
            check("ar_irq_refire", 32'(bus.irq), 32'd2);
        end
        chk_rd("ar_ch0_ctrl", a(0, 0), 32'h08);
        chk_rd("ar_ch0_pre",  a(0, 1), 32'd3);
        chk_rd("ar_ch0_cnt",  a(0, 2), 32'd0);
        do_reset();

        // Masking on ch0
        wr(a(0, 1), 32'd1);
        wr(a(0, 0), 32'h1);
        step(); step(); step();
        chk_rd("mask_ctrl", a(0, 0), 32'h11);
        check("mask_irq", 32'(bus.irq), 32'd0);
        check("mask_irqany", 32'(bus.irq_any), 32'd0);
        wr(a(0, 0), 32'h18);
        chk_rd("mask_ctrl2", a(0, 0), 32'h08);
        check("mask_irq2", 32'(bus.irq), 32'd0);

        // PRESET=0 fires 3 edges after enable
        wr(a(1, 1), 32'd0);
        wr(a(1, 0), 32'h9);
        step(); step();
        chk_rd("p0_ctrl_t2", a(1, 0), 32'h09);
        step();
        chk_rd("p0_ctrl_t3", a(1, 0), 32'h19);
        check("p0_irq_t3", 32'(bus.irq), 32'd2);

        // Width truncation and unmapped addresses
        wr(a(1, 1), 32'h1FF);
        chk_rd("trunc_pre", a(1, 1), 32'hFF);
        wr(a(2, 1), 32'h55);
        wr(a(0, 3), 32'hFFFF_FFFF);
        chk_rd("alias_ch0_pre", a(0, 1), 32'd1);
        chk_rd("alias_ch0_ctrl", a(0, 0), 32'h08);
        chk_rd("oor_ch2_pre", a(2, 1), 32'd0);
        chk_rd("oor_ch7_cnt", a(7, 2), 32'd0);
        chk_rd("rsv_0c", a(0, 3), 32'd0);
        do_reset();

        // W1C on the CNT->INT edge: set wins
        wr(a(0, 1), 32'd2);
        wr(a(0, 0), 32'h9);
        step(); step(); step();
        wr(a(0, 0), 32'h19);
        chk_rd("col_pend_ctrl", a(0, 0), 32'h19);
        step();
        chk_rd("col_pend_int", a(0, 0), 32'h18);

        // Software EN write on the one-shot INT edge wins
        wr(a(1, 1), 32'd1);
        wr(a(1, 0), 32'h9);
        step(); step(); step();
        wr(a(1, 0), 32'h9);
        chk_rd("col_en_ctrl", a(1, 0), 32'h19);
        check("col_en_idle", 32'(bus.state[3:2]), 32'(S_IDLE));
        step();
        check("col_en_load", 32'(bus.state[3:2]), 32'(S_LOAD));
        step();
        chk_rd("col_en_cnt", a(1, 2), 32'd1);
        do_reset();

        // Reset mid-count
        wr(a(1, 1), 32'd0);
        wr(a(1, 0), 32'h9);
        wr(a(0, 1), 32'd10);
        wr(a(0, 0), 32'h9);
        repeat (7) step();
        chk_rd("mid_cnt5", a(0, 2), 32'd5);
        check("mid_irq_pre", 32'(bus.irq), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_dout", bus.dout, 32'd0);
        check("mid_irq", 32'(bus.irq), 32'd0);
        check("mid_irqany", 32'(bus.irq_any), 32'd0);
        check("mid_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(); step();
        chk_rd("mid_cnt_after", a(0, 2), 32'd0);
        chk_rd("mid_ctrl_after", a(0, 0), 32'd0);
        check("mid_state_after", 32'(bus.state), 32'd0);

        // Randomized channel runs against the closed-form model
        for (int it = 0; it < 20; it++) begin
            int c, o, p, mode, im, op, L, nd, ec, ep, ee;
            do_reset();
            c    = int'($urandom_range(0, 1));
            o    = 1 - c;
            p    = int'($urandom_range(0, 12));
            mode = int'($urandom_range(0, 3));
            im   = int'($urandom_range(0, 1));
            op   = int'($urandom_range(0, 255));
            wr(a(o, 1), 32'(op));
            wr(a(c, 1), 32'(p | (int'($urandom_range(0, 7)) << 8)));
            wr(a(c, 0), 32'((im << 3) | (mode << 1) | 1));
            L  = ((p < 1) ? 1 : p) + 2;
            nd = (mode == 1) ? 2 * L + 2 : L + 2;
            for (int d = 1; d <= nd; d++) begin
                step();
                model(p, mode, d, ec, ep, ee);
                chk_rd("rnd_count", a(c, 2), 32'(ec));
                chk_rd("rnd_ctrl", a(c, 0), 32'((ep << 4) | (im << 3) | (mode << 1) | ee));
                check("rnd_irq", 32'(bus.irq), 32'((ep & im) << c));
            end
            chk_rd("rnd_other_pre", a(o, 1), 32'(op));
            chk_rd("rnd_other_ctrl", a(o, 0), 32'd0);
        end

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
